// File: rtl/riscv_pkg.sv
// Shared core definitions: result-source and load funct3 codes, writeback FSM states.
package riscv_pkg;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Selects the byte/halfword of an aligned load word at the given offset and
// sign- or zero-extends it according to the load funct3 code.
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = rdata[{off[1], 4'b0000} +: 16];

  // NOTE: every path assigns data, and the default arm covers LW plus the
  // unused codes, so this stays purely combinational with no latch.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: single-entry register driving the register-file write port,
// stalling on outstanding loads and emitting one retire pulse per instruction.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic [1:0]      in_result_src,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [4:0]      a3,
  output logic            we3,
  output logic [XLEN-1:0] wd3,
  output logic            retire,
  output logic            resp_err
);

  wb_state_t       state;
  logic [4:0]      rd_q;
  logic            reg_write_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] load_data;
  logic            in_write;
  logic            load_write;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  assign in_ready   = (state == IDLE);
  assign in_write   = in_reg_write && (in_rd != 5'd0);
  assign load_write = reg_write_q && (rd_q != 5'd0);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; the latched load fields are reset too so a3 never
  // picks up X from an abandoned load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      a3          <= '0;
      we3         <= 1'b0;
      wd3         <= '0;
      retire      <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      we3    <= 1'b0;
      retire <= 1'b0;
      case (state)
        IDLE: begin
          // A response with no load outstanding is dropped and flagged.
          if (mem_rvalid) resp_err <= 1'b1;
          if (in_valid) begin
            if (in_result_src == RES_LOAD) begin
              rd_q        <= in_rd;
              reg_write_q <= in_reg_write;
              funct3_q    <= in_funct3;
              off_q       <= in_alu_result[1:0];
              state       <= WAIT_MEM;
            end else begin
              retire <= 1'b1;
              we3    <= in_write;
              if (in_write) begin
                a3  <= in_rd;
                wd3 <= (in_result_src == RES_PC4) ? in_pc_plus4 : in_alu_result;
              end
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            retire <= 1'b1;
            we3    <= load_write;
            if (load_write) begin
              a3  <= rd_q;
              wd3 <= load_data;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_result_src;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  a3;
  logic        we3;
  logic [31:0] wd3;
  logic        retire;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_result_src (in_result_src),
    .in_funct3     (in_funct3),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .a3            (a3),
    .we3           (we3),
    .wd3           (wd3),
    .retire        (retire),
    .resp_err      (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] src, input logic [4:0] rd, input logic rw,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
    in_valid      = 1'b1;
    in_result_src = src;
    in_rd         = rd;
    in_reg_write  = rw;
    in_funct3     = f3;
    in_alu_result = alu;
    in_pc_plus4   = pc4;
  endtask

  // Load to rd 10 at address addr; response arrives three cycles after transfer.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
    issue(2'b01, 5'd10, 1'b1, f3, addr, 32'h0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check({tag, "_wait_ready"}, {31'b0, in_ready}, 32'd0);
      check({tag, "_wait_we3"}, {31'b0, we3}, 32'd0);
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80AB_CDEF;
    step();
    mem_rvalid = 1'b0;
    check({tag, "_we3"}, {31'b0, we3}, 32'd1);
    check({tag, "_a3"}, {27'b0, a3}, 32'd10);
    check({tag, "_wd3"}, wd3, exp);
    check({tag, "_retire"}, {31'b0, retire}, 32'd1);
    check({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    step();
    check({tag, "_we3_off"}, {31'b0, we3}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0;
    in_result_src = '0; in_funct3 = '0; in_alu_result = '0; in_pc_plus4 = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    check("rst_we3", {31'b0, we3}, 32'd0);
    check("rst_a3", {27'b0, a3}, 32'd0);
    check("rst_wd3", wd3, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;

    // ALU write
    issue(2'b00, 5'd5, 1'b1, 3'd0, 32'h1234_5678, 32'h0000_0444);
    step();
    in_valid = 1'b0;
    check("alu_we3", {31'b0, we3}, 32'd1);
    check("alu_a3", {27'b0, a3}, 32'd5);
    check("alu_wd3", wd3, 32'h1234_5678);
    check("alu_retire", {31'b0, retire}, 32'd1);
    step();
    check("alu_we3_off", {31'b0, we3}, 32'd0);
    check("alu_retire_off", {31'b0, retire}, 32'd0);

    // Write to x0 is blocked but still retires
    issue(2'b00, 5'd0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0);
    step();
    in_valid = 1'b0;
    check("x0_we3", {31'b0, we3}, 32'd0);
    check("x0_retire", {31'b0, retire}, 32'd1);

    // reg_write low: no write, still retires
    issue(2'b00, 5'd6, 1'b0, 3'd0, 32'h0000_0001, 32'h0);
    step();
    in_valid = 1'b0;
    check("nowr_we3", {31'b0, we3}, 32'd0);
    check("nowr_retire", {31'b0, retire}, 32'd1);
    step();

    // Loads against word 0x80AB_CDEF
    run_load("lb3",  3'b000, 32'h0000_1003, 32'hFFFF_FF80);
    run_load("lbu3", 3'b100, 32'h0000_1003, 32'h0000_0080);
    run_load("lb1",  3'b000, 32'h0000_1001, 32'hFFFF_FFCD);
    run_load("lbu0", 3'b100, 32'h0000_1000, 32'h0000_00EF);
    run_load("lh2",  3'b001, 32'h0000_1002, 32'hFFFF_80AB);
    run_load("lh0",  3'b001, 32'h0000_1000, 32'hFFFF_CDEF);
    run_load("lhu0", 3'b101, 32'h0000_1000, 32'h0000_CDEF);
    run_load("lhu2", 3'b101, 32'h0000_1002, 32'h0000_80AB);
    run_load("lw",   3'b010, 32'h0000_1000, 32'h80AB_CDEF);

    // Back-to-back JAL then ALU
    issue(2'b10, 5'd1, 1'b1, 3'd0, 32'h0000_DEAD, 32'h0000_0100);
    step();
    check("jal_we3", {31'b0, we3}, 32'd1);
    check("jal_a3", {27'b0, a3}, 32'd1);
    check("jal_wd3", wd3, 32'h0000_0100);
    check("jal_ready", {31'b0, in_ready}, 32'd1);
    issue(2'b00, 5'd2, 1'b1, 3'd0, 32'h0000_0007, 32'h0000_0200);
    step();
    check("b2b_we3", {31'b0, we3}, 32'd1);
    check("b2b_a3", {27'b0, a3}, 32'd2);
    check("b2b_wd3", wd3, 32'h0000_0007);
    check("b2b_retire", {31'b0, retire}, 32'd1);
    check("b2b_ready", {31'b0, in_ready}, 32'd1);
    // Reserved result source behaves as ALU
    issue(2'b11, 5'd3, 1'b1, 3'd0, 32'h0000_0033, 32'h0000_0300);
    step();
    in_valid = 1'b0;
    check("rsv_we3", {31'b0, we3}, 32'd1);
    check("rsv_wd3", wd3, 32'h0000_0033);
    step();
    check("b2b_we3_off", {31'b0, we3}, 32'd0);

    // Stray response while idle
    check("err_pre", {31'b0, resp_err}, 32'd0);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check("err_set", {31'b0, resp_err}, 32'd1);
    check("err_we3", {31'b0, we3}, 32'd0);
    check("err_retire", {31'b0, retire}, 32'd0);
    step();
    step();
    check("err_sticky", {31'b0, resp_err}, 32'd1);

    // Reset while waiting abandons the load even with a response present
    issue(2'b01, 5'd9, 1'b1, 3'b010, 32'h0000_2000, 32'h0);
    step();
    in_valid = 1'b0;
    check("abort_wait_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1111_2222;
    step();
    rst = 1'b0;
    mem_rvalid = 1'b0;
    check("abort_we3", {31'b0, we3}, 32'd0);
    check("abort_retire", {31'b0, retire}, 32'd0);
    check("abort_ready", {31'b0, in_ready}, 32'd1);
    check("abort_err_clr", {31'b0, resp_err}, 32'd0);
    step();
    check("abort_we3_after", {31'b0, we3}, 32'd0);
    check("abort_retire_after", {31'b0, retire}, 32'd0);

    // Response in the same cycle as the load transfer is stray
    issue(2'b01, 5'd12, 1'b1, 3'b010, 32'h0000_3000, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'hAAAA_AAAA;
    step();
    in_valid = 1'b0;
    mem_rvalid = 1'b0;
    check("same_err", {31'b0, resp_err}, 32'd1);
    check("same_ready", {31'b0, in_ready}, 32'd0);
    check("same_we3", {31'b0, we3}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_1234;
    step();
    mem_rvalid = 1'b0;
    check("same_wd3", wd3, 32'h5555_1234);
    check("same_a3", {27'b0, a3}, 32'd12);
    check("same_we3_load", {31'b0, we3}, 32'd1);

    // Load to x0 retires without writing
    issue(2'b01, 5'd0, 1'b1, 3'b010, 32'h0000_3000, 32'h0);
    step();
    in_valid = 1'b0;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check("ldx0_we3", {31'b0, we3}, 32'd0);
    check("ldx0_retire", {31'b0, retire}, 32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the core: a single-entry MEM/WB register that takes completed instructions from the memory stage and produces the register-file write port (`a3`, `we3`, `wd3`). It waits for data-memory responses on loads and sign/zero-extends sub-word load data. It blocks writes to x0 and emits a one-cycle retire pulse per completed instruction. Its outputs connect directly to the register file's write port.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  memory stage presents an instruction.
- `in_ready`  out  1  stage can accept; `in_valid && in_ready` is a transfer.
- `in_rd`  in  5  destination register.
- `in_reg_write`  in  1  instruction writes `rd`.
- `in_result_src`  in  2  result source: 00 = ALU, 01 = load, 10 = PC+4, 11 = reserved (treated as ALU).
- `in_funct3`  in  3  load width/sign code.
- `in_alu_result`  in  XLEN  ALU result; also the load address (bits [1:0] are the byte offset).
- `in_pc_plus4`  in  XLEN  link value.
- `mem_rvalid`  in  1  data-memory read response valid.
- `mem_rdata`  in  XLEN  aligned 32-bit word from data memory.
- `a3`  out  5  register-file write address.
- `we3`  out  1  register-file write enable.
- `wd3`  out  XLEN  register-file write data.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `resp_err`  out  1  sticky flag: `mem_rvalid` arrived with no load outstanding.

## Operation
- FSM states: IDLE and WAIT_MEM.
- `in_ready` = (state == IDLE). It is combinational from state only and never depends on `in_valid`.
- Transfer in IDLE, non-load:
  - Next cycle: `we3` = `in_reg_write && (in_rd != 0)`, `a3` = `in_rd`, `wd3` = ALU result or PC+4, `retire` = 1.
  - State stays IDLE.
- Transfer in IDLE, load:
  - Latch `rd`, `reg_write`, `funct3` and offset = `in_alu_result[1:0]`.
  - Next cycle: `we3` = 0, `retire` = 0; state goes to WAIT_MEM.
- WAIT_MEM with `mem_rvalid` = 1:
  - Next cycle: `wd3` = extend(`mem_rdata`), `we3` = `reg_write && (rd != 0)`, `a3` = rd, `retire` = 1.
  - State goes to IDLE.
- WAIT_MEM with `mem_rvalid` = 0: hold the state and all latched fields; `we3` = 0.
- Load extension:
  - LB (000): byte at offset, sign-extended. LBU (100): same byte, zero-extended.
  - LH (001): halfword at offset[1], sign-extended. LHU (101): same halfword, zero-extended.
  - LW (010) and any other code: full word, no extension.
  - Byte select = `mem_rdata[8*off +: 8]`; halfword select = `mem_rdata[16*off[1] +: 16]`. Misalignment is not checked.
- `mem_rvalid` in IDLE: the response is ignored and `resp_err` is set to 1. It stays 1 until reset.
- When `we3` = 0, `a3` and `wd3` hold their last values and are don't-care to the register file.

## Timing
- Reset values: state IDLE, `we3` 0, `a3` 0, `wd3` 0, `retire` 0, `resp_err` 0. `in_ready` reads 1 in the first cycle after reset.
- Reset has priority over all other inputs.
- Reset while in WAIT_MEM abandons the load: no write and no retire, even if `mem_rvalid` is high in the same cycle.
- Latency:
  - Non-load: transfer at cycle N gives `we3`/`retire` at N+1.
  - Load: `mem_rvalid` at cycle M (M ≥ N+1) gives write at M+1.
- Throughput: one non-load per cycle, back-to-back. A load blocks new transfers until its response has been consumed.
- `mem_rvalid` in the same cycle as the load's transfer belongs to no outstanding load, so it sets `resp_err`.
- `we3` and `retire` are single-cycle pulses per instruction. They are never asserted in two consecutive cycles for the same instruction.

## Structure
- Shared package `riscv_pkg`:
  - result-source codes: RES_ALU, RES_LOAD, RES_PC4;
  - load funct3 codes: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - `wb_state_t` enum: IDLE, WAIT_MEM.
- One combinational sub-module `load_extend`, with ports (`rdata`, `off`, `funct3` → `data`). It is reusable by a later forwarding unit.

## Test plan
- Reset, then ALU instruction (rd = 5, result 0x1234_5678) → next cycle `we3` = 1, `a3` = 5, `wd3` = 0x1234_5678, `retire` = 1; at the following idle cycle `we3` = 0.
- ALU instruction with rd = 0, result 0xFFFF_FFFF → `we3` = 0, `retire` = 1.
- LB at offset 3, `mem_rdata` = 0x80AB_CDEF, `mem_rvalid` three cycles later:
  - `in_ready` is 0 during the wait;
  - one cycle after `mem_rvalid`: `wd3` = 0xFFFF_FF80.
  - Repeat as LBU → 0x0000_0080. LH at offset 2 → 0xFFFF_80AB. LHU at offset 0 → 0x0000_CDEF.
- Back-to-back JAL (rd = 1, pc_plus4 = 0x100) then ALU (rd = 2, 0x7):
  - two consecutive write cycles with correct `a3`/`wd3`;
  - `in_ready` stays 1 throughout.
- `mem_rvalid` pulsed while IDLE → `resp_err` = 1 and no write; `resp_err` stays 1 until `rst` clears it.
- Load accepted, `rst` asserted while in WAIT_MEM, `mem_rvalid` high in the same cycle → no `we3`, no `retire`; state is IDLE; `in_ready` = 1 next cycle.
